// File: rtl/uart_fifo.sv
// UART with a 4-register CPU bus, TX/RX FIFOs, programmable bit divisor and optional parity.
// Divisor and parity mode are latched per frame so bus writes never disturb a frame in flight.
module uart_fifo #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] dbr,
    input  logic [7:0] dbw,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic       re,
    output logic       tx,
    input  logic       rx,
    output logic       irq
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 12;
    localparam logic [DW-1:0] DIV_RST = DW'(CLK_HZ / BAUD - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Programmable registers and sticky error flags
    logic [DW-1:0] r_div;
    logic          r_par_en;
    logic          r_par_odd;
    logic          r_rx_ie;
    logic          r_err_ie;
    logic          r_ovr;
    logic          r_fe;
    logic          r_pe;
    logic [7:0]    r_dbr;
    logic          r_irq;

    // FIFO storage and pointers
    logic [7:0]    r_txf_mem [FIFO_DEPTH];
    logic [AW-1:0] r_txf_wr;
    logic [AW-1:0] r_txf_rd;
    logic [CW-1:0] r_txf_cnt;
    logic [7:0]    r_rxf_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rxf_wr;
    logic [AW-1:0] r_rxf_rd;
    logic [CW-1:0] r_rxf_cnt;

    // Transmitter
    tx_state_t     r_tx_state;
    logic          r_tx;
    logic [DW-1:0] r_tx_bcnt;
    logic [DW-1:0] r_tx_div;
    logic [7:0]    r_tx_shift;
    logic [2:0]    r_tx_idx;
    logic          r_tx_par;
    logic          r_tx_par_en;

    // Receiver
    rx_state_t     r_rx_state;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_d;
    logic [DW-1:0] r_rx_bcnt;
    logic [DW-1:0] r_rx_div;
    logic [7:0]    r_rx_shift;
    logic [2:0]    r_rx_idx;
    logic          r_rx_par_bit;
    logic          r_rx_par_en;
    logic          r_rx_par_odd;

    logic          w_bus_rd;
    logic          w_txf_full;
    logic          w_txf_empty;
    logic          w_tx_push_ok;
    logic          w_tx_pop;
    logic [7:0]    w_tx_head;
    logic          w_rxf_full;
    logic          w_rxf_empty;
    logic          w_rx_pop;
    logic          w_rx_push;
    logic          w_rx_push_ok;
    logic [7:0]    w_rx_head;
    logic          w_ovr_set;
    logic          w_fe_set;
    logic          w_pe_set;
    logic [2:0]    w_clr;
    logic          w_tx_idle;
    logic [7:0]    w_status;
    logic [DW-1:0] w_div_eff;
    logic [DW-1:0] w_rx_half_m1;

    assign w_bus_rd     = re & ~we;
    assign w_txf_full   = (r_txf_cnt == CW'(FIFO_DEPTH));
    assign w_txf_empty  = (r_txf_cnt == '0);
    assign w_tx_push_ok = we & (addr == 2'd0) & ~w_txf_full;
    assign w_tx_head    = r_txf_mem[r_txf_rd];
    assign w_tx_pop     = ~w_txf_empty & ((r_tx_state == TX_IDLE) |
                          ((r_tx_state == TX_STOP) & (r_tx_bcnt == r_tx_div)));

    assign w_rxf_full   = (r_rxf_cnt == CW'(FIFO_DEPTH));
    assign w_rxf_empty  = (r_rxf_cnt == '0);
    assign w_rx_head    = r_rxf_mem[r_rxf_rd];
    assign w_rx_pop     = w_bus_rd & (addr == 2'd0) & ~w_rxf_empty;
    assign w_rx_push    = (r_rx_state == RX_STOP) & (r_rx_bcnt == r_rx_div);
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign w_rx_push_ok = w_rx_push & (~w_rxf_full | w_rx_pop);
    assign w_ovr_set    = w_rx_push & w_rxf_full & ~w_rx_pop;
    assign w_fe_set     = w_rx_push & ~r_rx_s2;
    assign w_pe_set     = w_rx_push & r_rx_par_en &
                          (r_rx_par_bit != (^r_rx_shift ^ r_rx_par_odd));

    assign w_clr        = (we && addr == 2'd1) ? dbw[4:2] : 3'b000;
    assign w_tx_idle    = w_txf_empty & (r_tx_state == TX_IDLE);
    assign w_status     = {w_txf_full, ~w_rxf_empty, w_tx_idle, r_ovr, r_fe, r_pe, 2'b00};
    assign w_div_eff    = (r_div < DW'(3)) ? DW'(3) : r_div;
    assign w_rx_half_m1 = DW'((({1'b0, r_rx_div} + 13'd1) >> 1) - 13'd1);

    assign dbr = r_dbr;
    assign tx  = r_tx;
    assign irq = r_irq;

    // Bus registers, read data, error flags and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= DIV_RST;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_rx_ie   <= 1'b0;
            r_err_ie  <= 1'b0;
            r_ovr     <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
            r_dbr     <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            if (we) begin
                case (addr)
                    2'd2: r_div[7:0] <= dbw;
                    2'd3: begin
                        r_div[11:8] <= dbw[3:0];
                        r_par_en    <= dbw[4];
                        r_par_odd   <= dbw[5];
                        r_rx_ie     <= dbw[6];
                        r_err_ie    <= dbw[7];
                    end
                    default: ;
                endcase
            end
            r_ovr <= (r_ovr & ~w_clr[2]) | w_ovr_set;
            r_fe  <= (r_fe  & ~w_clr[1]) | w_fe_set;
            r_pe  <= (r_pe  & ~w_clr[0]) | w_pe_set;
            if (w_bus_rd) begin
                case (addr)
                    2'd0: r_dbr <= w_rx_pop ? w_rx_head : 8'h00;
                    2'd1: r_dbr <= w_status;
                    2'd2: r_dbr <= r_div[7:0];
                    2'd3: r_dbr <= {r_err_ie, r_rx_ie, r_par_odd, r_par_en, r_div[11:8]};
                endcase
            end
            r_irq <= (r_rx_ie & ~w_rxf_empty) | (r_err_ie & (r_ovr | r_fe | r_pe));
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push_ok) r_txf_mem[r_txf_wr] <= dbw;
        if (w_rx_push_ok) r_rxf_mem[r_rxf_wr] <= r_rx_shift;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txf_wr  <= '0;
            r_txf_rd  <= '0;
            r_txf_cnt <= '0;
            r_rxf_wr  <= '0;
            r_rxf_rd  <= '0;
            r_rxf_cnt <= '0;
        end else begin
            if (w_tx_push_ok) r_txf_wr <= r_txf_wr + AW'(1);
            if (w_tx_pop)     r_txf_rd <= r_txf_rd + AW'(1);
            case ({w_tx_push_ok, w_tx_pop})
                2'b10:   r_txf_cnt <= r_txf_cnt + CW'(1);
                2'b01:   r_txf_cnt <= r_txf_cnt - CW'(1);
                default: ;
            endcase
            if (w_rx_push_ok) r_rxf_wr <= r_rxf_wr + AW'(1);
            if (w_rx_pop)     r_rxf_rd <= r_rxf_rd + AW'(1);
            case ({w_rx_push_ok, w_rx_pop})
                2'b10:   r_rxf_cnt <= r_rxf_cnt + CW'(1);
                2'b01:   r_rxf_cnt <= r_rxf_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Transmitter: a pop launches the start bit on the same edge, from IDLE or end of STOP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx        <= 1'b1;
            r_tx_bcnt   <= '0;
            r_tx_div    <= DW'(3);
            r_tx_shift  <= 8'h00;
            r_tx_idx    <= 3'd0;
            r_tx_par    <= 1'b0;
            r_tx_par_en <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_state  <= TX_START;
            r_tx        <= 1'b0;
            r_tx_bcnt   <= '0;
            r_tx_div    <= w_div_eff;
            r_tx_shift  <= w_tx_head;
            r_tx_par    <= ^w_tx_head ^ r_par_odd;
            r_tx_par_en <= r_par_en;
        end else if (r_tx_state != TX_IDLE) begin
            if (r_tx_bcnt != r_tx_div) begin
                r_tx_bcnt <= r_tx_bcnt + DW'(1);
            end else begin
                r_tx_bcnt <= '0;
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_idx   <= 3'd0;
                    end
                    TX_DATA: begin
                        if (r_tx_idx == 3'd7) begin
                            r_tx_state <= r_tx_par_en ? TX_PARITY : TX_STOP;
                            r_tx       <= r_tx_par_en ? r_tx_par : 1'b1;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end
                    TX_PARITY: begin
                        r_tx_state <= TX_STOP;
                        r_tx       <= 1'b1;
                    end
                    default: begin
                        r_tx_state <= TX_IDLE;
                        r_tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Receiver: falling edge of synchronised rx arms; start bit re-checked at half period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_d       <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_bcnt    <= '0;
            r_rx_div     <= DW'(3);
            r_rx_shift   <= 8'h00;
            r_rx_idx     <= 3'd0;
            r_rx_par_bit <= 1'b0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            case (r_rx_state)
                RX_IDLE: begin
                    // Needs a seen-high level first, so a stuck-low line after a bad stop never re-arms
                    if (r_rx_d && !r_rx_s2) begin
                        r_rx_state   <= RX_START;
                        r_rx_bcnt    <= '0;
                        r_rx_div     <= w_div_eff;
                        r_rx_par_en  <= r_par_en;
                        r_rx_par_odd <= r_par_odd;
                    end
                end
                RX_START: begin
                    if (r_rx_bcnt != w_rx_half_m1) begin
                        r_rx_bcnt <= r_rx_bcnt + DW'(1);
                    end else begin
                        r_rx_bcnt  <= '0;
                        r_rx_idx   <= 3'd0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA, RX_PARITY, RX_STOP: begin
                    if (r_rx_bcnt != r_rx_div) begin
                        r_rx_bcnt <= r_rx_bcnt + DW'(1);
                    end else begin
                        r_rx_bcnt <= '0;
                        if (r_rx_state == RX_DATA) begin
                            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                            r_rx_idx   <= r_rx_idx + 3'd1;
                            if (r_rx_idx == 3'd7)
                                r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
                        end else if (r_rx_state == RX_PARITY) begin
                            r_rx_par_bit <= r_rx_s2;
                            r_rx_state   <= RX_STOP;
                        end else begin
                            r_rx_state <= RX_IDLE;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: TX waveform, FIFO limits, RX parity/frame/overrun, glitch and reset.
module tb_uart_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dbr;
    logic [7:0] dbw;
    logic [1:0] addr;
    logic       we;
    logic       re;
    logic       tx;
    logic       rx;
    logic       irq;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_bytes [17];
    int         f;

    uart_fifo #(.CLK_HZ(25000000), .BAUD(115200), .FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .dbr (dbr),
        .dbw (dbw),
        .addr(addr),
        .we  (we),
        .re  (re),
        .tx  (tx),
        .rx  (rx),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        dbw  = d;
        we   = 1'b1;
        tick(1);
        we   = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        re   = 1'b1;
        tick(1);
        re   = 1'b0;
        d    = dbr;
    endtask

    // Expected tx level 'off' clocks into a no-parity frame with bit period 'per'
    function automatic logic frame_bit(input logic [7:0] d, input int off, input int per);
        int b;
        b = off / per;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Drive one serial frame at 5 clocks per bit; optionally pop RX on the stop-sample edge
    task automatic send_rx(input logic [7:0] d, input bit use_par, input bit par_bit,
                           input bit stop_bit, input bit pop_at_stop, output logic [7:0] popped);
        popped = 8'h00;
        rx = 1'b0;
        tick(5);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(5);
        end
        if (use_par) begin
            rx = par_bit;
            tick(5);
        end
        rx = stop_bit;
        if (pop_at_stop) begin
            tick(4);
            addr = 2'd0;
            re   = 1'b1;
            tick(1);
            re     = 1'b0;
            popped = dbr;
        end else begin
            tick(5);
        end
    endtask

    initial begin
        #5000000;
        errors++;
        checks++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] v;
        rst  = 1'b1;
        we   = 1'b0;
        re   = 1'b0;
        addr = 2'd0;
        dbw  = 8'h00;
        rx   = 1'b1;
        tick(3);
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_dbr", 16'(dbr), 16'h00);
        check("rst_irq", 16'(irq), 16'd0);
        rst = 1'b0;
        tick(1);
        bus_rd(2'd1, v); check("rst_status", 16'(v), 16'h20);
        bus_rd(2'd2, v); check("rst_div_lo", 16'(v), 16'hD8);
        bus_rd(2'd3, v); check("rst_ctrl", 16'(v), 16'h00);

        // DIV=4: 0xA5 frame, 5 clocks per bit, start low from the edge after the push
        bus_wr(2'd2, 8'd4);
        bus_wr(2'd0, 8'hA5);
        check("tx_before_start", 16'(tx), 16'd1);
        for (int c = 1; c <= 55; c++) begin
            tick(1);
            check("tx_a5_wave", 16'(tx), 16'(frame_bit(8'hA5, c - 1, 5)));
        end
        bus_rd(2'd1, v); check("status_after_a5", 16'(v), 16'h20);

        // DIV=1 is clamped to 3: 4 clocks per bit, register still reads back 1
        bus_wr(2'd2, 8'd1);
        bus_rd(2'd2, v); check("div_raw_readback", 16'(v), 16'h01);
        bus_wr(2'd0, 8'h55);
        for (int c = 1; c <= 45; c++) begin
            tick(1);
            check("tx_clamp_wave", 16'(tx), 16'(frame_bit(8'h55, c - 1, 4)));
        end

        // DIV=9: one frame in flight, 17 more pushes -> 16 stored, last dropped
        bus_wr(2'd2, 8'd9);
        bus_wr(2'd0, 8'h3C);
        tx_bytes[0] = 8'h3C;
        for (int i = 1; i <= 17; i++) begin
            bus_wr(2'd0, 8'(i));
            if (i < 17) tx_bytes[i] = 8'(i);
        end
        bus_rd(2'd1, v); check("tx_full_status", 16'(v), 16'h80);
        for (int c = 19; c <= 1720; c++) begin
            tick(1);
            f = (c - 1) / 100;
            if (f < 17) check("tx_b2b_wave", 16'(tx), 16'(frame_bit(tx_bytes[f], (c - 1) % 100, 10)));
            else        check("tx_b2b_tail", 16'(tx), 16'd1);
        end
        bus_rd(2'd1, v); check("status_after_b2b", 16'(v), 16'h20);

        // Even parity enabled, 0x07 received with wrong parity bit (0 instead of 1)
        bus_wr(2'd3, 8'h90);
        bus_wr(2'd2, 8'd4);
        send_rx(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, v);
        tick(2);
        check("irq_parity", 16'(irq), 16'd1);
        bus_wr(2'd0, 8'h00);
        bus_rd(2'd1, v); check("status_parity", 16'(v), 16'h44);
        bus_rd(2'd0, v); check("rx_parity_byte", 16'(v), 16'h07);
        bus_wr(2'd1, 8'h1C);
        tick(2);
        check("irq_cleared", 16'(irq), 16'd0);
        tick(70);
        bus_rd(2'd1, v); check("status_parity_clr", 16'(v), 16'h20);

        // 17 frames with no reads: first 16 kept in order, overrun set
        bus_wr(2'd3, 8'h00);
        for (int i = 0; i < 17; i++) send_rx(8'(8'h30 + i), 1'b0, 1'b0, 1'b1, 1'b0, v);
        tick(2);
        bus_rd(2'd1, v); check("status_overrun", 16'(v), 16'h70);
        for (int i = 0; i < 16; i++) begin
            bus_rd(2'd0, v);
            check("rx_order", 16'(v), 16'(8'h30 + i));
        end
        bus_rd(2'd0, v); check("rx_pop_empty", 16'(v), 16'h00);
        bus_wr(2'd1, 8'h10);
        bus_rd(2'd1, v); check("status_ovr_clr", 16'(v), 16'h20);

        // Full RX FIFO, pop coinciding with the 17th push: both happen, no overrun
        for (int i = 0; i < 16; i++) send_rx(8'(8'h50 + i), 1'b0, 1'b0, 1'b1, 1'b0, v);
        send_rx(8'h60, 1'b0, 1'b0, 1'b1, 1'b1, v);
        check("rx_coincident_pop", 16'(v), 16'h50);
        tick(2);
        bus_rd(2'd1, v); check("status_no_overrun", 16'(v), 16'h60);
        for (int i = 1; i <= 16; i++) begin
            bus_rd(2'd0, v);
            check("rx_order_2", 16'(v), (i < 16) ? 16'(8'h50 + i) : 16'h60);
        end
        bus_rd(2'd1, v); check("status_drained", 16'(v), 16'h20);

        // One-clock low glitch is rejected; a following frame still arrives
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        bus_rd(2'd1, v); check("status_glitch", 16'(v), 16'h20);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, v);
        tick(2);
        bus_rd(2'd0, v); check("rx_after_glitch", 16'(v), 16'h5A);

        // Stop bit low: byte still pushed, frame_err set, no re-arm while the line stays low
        send_rx(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, v);
        tick(10);
        bus_rd(2'd1, v); check("status_frame_err", 16'(v), 16'h68);
        bus_rd(2'd0, v); check("rx_frame_err_byte", 16'(v), 16'hC3);
        tick(20);
        bus_rd(2'd1, v); check("status_line_low", 16'(v), 16'h28);
        rx = 1'b1;
        tick(5);
        send_rx(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, v);
        tick(2);
        bus_rd(2'd1, v); check("status_rearm", 16'(v), 16'h68);
        bus_rd(2'd0, v); check("rx_rearm_byte", 16'(v), 16'h11);
        bus_wr(2'd1, 8'h08);
        bus_rd(2'd1, v); check("status_fe_clr", 16'(v), 16'h20);

        // Reset in the middle of a TX frame
        bus_wr(2'd2, 8'd4);
        bus_wr(2'd0, 8'h00);
        tick(10);
        check("tx_mid_frame", 16'(tx), 16'd0);
        rst = 1'b1;
        tick(1);
        check("tx_after_rst", 16'(tx), 16'd1);
        rst = 1'b0;
        bus_rd(2'd1, v); check("status_after_rst", 16'(v), 16'h20);
        bus_rd(2'd2, v); check("div_after_rst", 16'(v), 16'hD8);
        bus_rd(2'd3, v); check("ctrl_after_rst", 16'(v), 16'h00);
        check("irq_after_rst", 16'(irq), 16'd0);
        tick(20);
        check("tx_stays_idle", 16'(tx), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, master clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO; power of two, 2..256.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port dbr  output  8  data bus read, registered.
REQ-007 SHALL have port dbw  input  8  data bus write.
REQ-008 SHALL have port addr  input  2  register select.
REQ-009 SHALL have port we  input  1  write strobe, one access per cycle high.
REQ-010 SHALL have port re  input  1  read strobe, one access per cycle high; we has priority if both are high.
REQ-011 SHALL have port tx  output  1  serial out, idle high.
REQ-012 SHALL have port rx  input  1  serial in, asynchronous.
REQ-013 SHALL have port irq  output  1  interrupt, level, active-high.

Function
REQ-014 SHALL decode registers as follows. Addr 0 write pushes the TX FIFO; addr 0 read pops the RX FIFO into dbr.
REQ-015 SHALL return STATUS on an addr 1 read: {tx_full, rx_avail, tx_idle, overrun, frame_err, parity_err, 2'b0}. An addr 1 write clears bits [4:2] wherever the corresponding dbw bit is 1.
REQ-016 SHALL map addr 2 to DIV[7:0] (read/write).
REQ-017 SHALL map addr 3 to CTRL (read/write): [3:0]=DIV[11:8], [4]=par_en, [5]=par_odd, [6]=rx_ie, [7]=err_ie.
REQ-018 SHALL update dbr one cycle after a read strobe and hold it otherwise. A pop of an empty RX FIFO SHALL load 0x00 without moving pointers.
REQ-019 SHALL give a bit period of DIV+1 clocks. DIV SHALL be latched at each TX and RX frame start, so a mid-frame write affects only the next frame. DIV<3 SHALL be treated as 3.
REQ-020 SHALL frame data as start(0), 8 data bits LSB first, parity (only if par_en; even unless par_odd), stop(1).
REQ-021 SHALL implement TX as a state machine IDLE -> START -> DATA(8) -> [PARITY] -> STOP -> IDLE.
REQ-022 SHALL, when the TX FIFO is non-empty in IDLE, pop it and drive tx=0 on the same edge. Latency: a push at edge N to an empty, idle transmitter gives tx low from edge N+1.
REQ-023 SHALL, after STOP, go directly to START with no extra idle bit when the TX FIFO is non-empty.
REQ-024 SHALL drop a TX push to a full FIFO with no state change. tx_full SHALL be 1 when the count equals FIFO_DEPTH.
REQ-025 SHALL assert tx_idle when the TX FIFO is empty and the TX state is IDLE.
REQ-026 SHALL synchronise rx through 2 flops and use only the synchronised signal.
REQ-027 SHALL implement RX as a state machine IDLE -> START -> DATA(8) -> [PARITY] -> STOP -> IDLE.
REQ-028 SHALL start RX on a synchronised 1->0 transition in IDLE, then sample the start bit after (DIV+1)/2 clocks (integer). If it is sampled high, RX SHALL return to IDLE (glitch) with no push.
REQ-029 SHALL sample each subsequent RX bit DIV+1 clocks after the previous sample.
REQ-030 SHALL, at the stop sample, push the byte to the RX FIFO and set frame_err if stop=0 and parity_err if parity mismatches. The byte SHALL still be pushed.
REQ-031 SHALL, if the RX FIFO is full at push, discard the byte and set overrun. If a CPU pop occurs in the same cycle as that push, both SHALL happen, with no overrun and the count unchanged.
REQ-032 SHALL, after a stop bit sampled 0, return RX to IDLE and re-arm only after the synchronised rx is seen high.
REQ-033 SHALL keep FIFO pointers at log2(FIFO_DEPTH) bits, wrapping modulo depth, with a count of log2(FIFO_DEPTH)+1 bits. A simultaneous push and pop SHALL leave the count unchanged.
REQ-034 SHALL drive irq registered as (rx_ie & rx_avail) | (err_ie & (overrun|frame_err|parity_err)).
REQ-035 SHALL drop error flags only on a clear write or reset; a clear in the same cycle as a new error SHALL leave the flag set.

Reset
REQ-036 SHALL, on rst high at an edge, set tx=1, dbr=0x00, irq=0, both FIFOs empty, both state machines IDLE, and error flags 0.
REQ-037 SHALL, on reset, load DIV=CLK_HZ/BAUD-1 (truncated to 12 bits) and CTRL[7:4]=0.
REQ-038 SHALL let reset mid-frame abort the frame: tx is high from the next edge and no partial byte is pushed.

Verification
REQ-039 SHALL cover: DIV=4, push 0xA5 at edge N -> tx low N+1..N+5, then bits 1,0,1,0,0,1,0,1 each 5 clocks, then stop high.
REQ-040 SHALL cover: push 17 bytes with FIFO_DEPTH=16 while TX is stalled by a slow DIV -> 17th byte lost, tx_full=1, 16 frames transmitted back-to-back with no idle gap.
REQ-041 SHALL cover: par_en=1, par_odd=0, RX 0x07 with wrong parity -> RX FIFO holds 0x07, STATUS=0x44 (rx_avail+parity_err), irq=1 with err_ie=1.
REQ-042 SHALL cover: RX 17 bytes without reads -> first 16 returned in order, overrun=1; a pop coinciding with the 17th push -> no overrun.
REQ-043 SHALL cover: 1-clock low glitch on rx -> no push, RX back in IDLE; stop bit forced 0 -> frame_err=1 and the byte pushed.
REQ-044 SHALL cover: assert rst mid-TX frame -> tx=1 next edge, tx_idle=1, DIV back to its default.
